// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg: shared state encoding and index-width helper for the packet arbiter
package axis_arb_pkg;
  typedef enum logic {IDLE, PKT} state_t;
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/axis_rr_pick.sv
// axis_rr_pick: combinational round-robin picker, first requester after last, wrapping
module axis_rr_pick
  import axis_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  localparam int IW = idx_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IW-1:0]      last,
  output logic [IW-1:0]      gnt_idx,
  output logic               gnt_any
);
  logic [IW-1:0] j;
  // scan from farthest to nearest so the nearest requester after last wins
  always_comb begin
    gnt_idx = '0;
    j = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      j = IW'((int'(last) + k) % NUM_SRC);
      if (req[j]) gnt_idx = j;
    end
  end
  assign gnt_any = |req;
endmodule

// File: rtl/axis_pkt_arbiter.sv
// axis_pkt_arbiter: packet-granular round-robin AXIS arbiter with registered master output
module axis_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int LEN_WIDTH = 16,
  localparam int IW = idx_width(NUM_SRC),
  localparam int SW = C_M_AXIS_TDATA_WIDTH / 8
) (
  input  logic                               M_AXIS_ACLK,
  input  logic                               M_AXIS_ARESETN,
  input  logic [NUM_SRC-1:0]                 S_AXIS_TVALID,
  input  logic [NUM_SRC*C_M_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic [NUM_SRC*SW-1:0]              S_AXIS_TSTRB,
  input  logic [NUM_SRC-1:0]                 S_AXIS_TLAST,
  output logic [NUM_SRC-1:0]                 S_AXIS_TREADY,
  output logic                               M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [SW-1:0]                      M_AXIS_TSTRB,
  output logic                               M_AXIS_TLAST,
  output logic [IW-1:0]                      M_AXIS_TID,
  input  logic                               M_AXIS_TREADY,
  output logic                               pkt_done,
  output logic [LEN_WIDTH-1:0]               pkt_len
);
  state_t state, state_nxt;
  logic [IW-1:0] grant, last_grant, pick_idx;
  logic pick_any, ready_g, accept, last_beat, sel_valid, sel_last;
  logic [C_M_AXIS_TDATA_WIDTH-1:0] sel_data;
  logic [SW-1:0] sel_strb;
  logic [LEN_WIDTH-1:0] cnt, cnt_inc;

  axis_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .req(S_AXIS_TVALID),
    .last(last_grant),
    .gnt_idx(pick_idx),
    .gnt_any(pick_any)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last = 1'b0;
    sel_data = '0;
    sel_strb = '0;
    for (int k = 0; k < NUM_SRC; k++)
      if (grant == IW'(k)) begin
        sel_valid = S_AXIS_TVALID[k];
        sel_last = S_AXIS_TLAST[k];
        sel_data = S_AXIS_TDATA[k*C_M_AXIS_TDATA_WIDTH +: C_M_AXIS_TDATA_WIDTH];
        sel_strb = S_AXIS_TSTRB[k*SW +: SW];
      end
  end

  // the output register can take a beat whenever it is empty or draining this cycle
  assign ready_g = (state == PKT) && (!M_AXIS_TVALID || M_AXIS_TREADY);
  assign accept = ready_g && sel_valid;
  assign last_beat = accept && sel_last;
  assign S_AXIS_TREADY = ready_g ? NUM_SRC'(1) << grant : '0;
  assign cnt_inc = &cnt ? cnt : cnt + 1'b1;

  always_comb begin
    state_nxt = state;
    if (state == IDLE) state_nxt = pick_any ? PKT : IDLE;
    else state_nxt = last_beat ? IDLE : PKT;
  end

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN)
    if (!M_AXIS_ARESETN) begin
      state <= IDLE;
      grant <= '0;
      last_grant <= IW'(NUM_SRC - 1);
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_any) grant <= pick_idx;
      if (last_beat) last_grant <= grant;
    end

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN)
    if (!M_AXIS_ARESETN) begin
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA <= '0;
      M_AXIS_TSTRB <= '0;
      M_AXIS_TLAST <= 1'b0;
      M_AXIS_TID <= '0;
      pkt_done <= 1'b0;
      pkt_len <= '0;
      cnt <= '0;
    end else begin
      pkt_done <= last_beat;
      if (accept) begin
        M_AXIS_TVALID <= 1'b1;
        M_AXIS_TDATA <= sel_data;
        M_AXIS_TSTRB <= sel_strb;
        M_AXIS_TLAST <= sel_last;
        M_AXIS_TID <= grant;
        cnt <= sel_last ? '0 : cnt_inc;
      end else if (M_AXIS_TREADY) M_AXIS_TVALID <= 1'b0;
      if (last_beat) pkt_len <= cnt_inc;
    end
endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// tb_axis_pkt_arbiter: directed scenario tasks for the packet round-robin arbiter
module tb_axis_pkt_arbiter;
  localparam int N = 4, W = 32, L = 16;
  logic clk = 1'b0, rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0] tv, tl, tr;
  logic [N*W-1:0] td;
  logic [N*W/8-1:0] ts;
  logic mv, ml, mready, done;
  logic [W-1:0] md;
  logic [W/8-1:0] ms;
  logic [1:0] mid;
  logic [L-1:0] plen;

  axis_pkt_arbiter #(.NUM_SRC(N), .C_M_AXIS_TDATA_WIDTH(W), .LEN_WIDTH(L)) dut (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_n),
    .S_AXIS_TVALID(tv), .S_AXIS_TDATA(td), .S_AXIS_TSTRB(ts), .S_AXIS_TLAST(tl),
    .S_AXIS_TREADY(tr),
    .M_AXIS_TVALID(mv), .M_AXIS_TDATA(md), .M_AXIS_TSTRB(ms), .M_AXIS_TLAST(ml),
    .M_AXIS_TID(mid), .M_AXIS_TREADY(mready),
    .pkt_done(done), .pkt_len(plen)
  );

  typedef struct {
    int stp;
    logic [1:0] tid;
    logic [W-1:0] data;
    logic [W/8-1:0] strb;
    logic last;
  } beat_t;

  int total = 0, bad = 0;
  int rem[N], len[N], pkts[N];
  logic [W-1:0] dat[N];
  beat_t got[$];
  int stepno, first_v, n_beats, n_done;
  logic s_tv, s_tl, s_tr;
  logic [W-1:0] s_td;
  logic [1:0] s_tid;

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      tv[i] = rem[i] > 0;
      tl[i] = rem[i] == 1;
      td[i*W +: W] = dat[i];
      ts[i*4 +: 4] = dat[i][3:0];
    end
  endtask

  task automatic load(input int s, input int l, input int p, input logic [W-1:0] d);
    rem[s] = l;
    len[s] = l;
    pkts[s] = p;
    dat[s] = d;
  endtask

  task automatic clear_tb();
    for (int i = 0; i < N; i++) load(i, 0, 0, '0);
    got.delete();
    stepno = 0;
    first_v = -1;
    n_beats = 0;
    n_done = 0;
    mready = 1'b1;
    drive();
  endtask

  task automatic reset_all();
    rst_n = 1'b0;
    clear_tb();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // one clock: drive sources, sample away from the edge, then apply source handshakes
  task automatic step();
    logic [N-1:0] hs;
    beat_t b;
    drive();
    #1;
    s_tv = mv; s_td = md; s_tl = ml; s_tid = mid; s_tr = mready;
    hs = tv & tr;
    if (mv && mready) begin
      n_beats++;
      b.stp = stepno; b.tid = mid; b.data = md; b.strb = ms; b.last = ml;
      if (got.size() < 64) got.push_back(b);
    end
    if (done) n_done++;
    if (mv && first_v < 0) first_v = stepno;
    stepno++;
    @(posedge clk);
    for (int i = 0; i < N; i++)
      if (hs[i]) begin
        dat[i] = dat[i] + 1;
        rem[i]--;
        if (rem[i] == 0 && pkts[i] > 1) begin
          pkts[i]--;
          rem[i] = len[i];
        end
      end
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_tb();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (mv !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b want=0", mv); end
    total++; if (md !== '0) begin bad++; $display("FAIL reset_tdata got=%h want=0", md); end
    total++; if (ms !== '0 || ml !== 1'b0 || mid !== '0) begin bad++; $display("FAIL reset_strb_last_tid got=%h/%b/%0d want=0/0/0", ms, ml, mid); end
    total++; if (tr !== '0) begin bad++; $display("FAIL reset_tready got=%b want=0000", tr); end
    total++; if (done !== 1'b0 || plen !== '0) begin bad++; $display("FAIL reset_pkt got=%b/%h want=0/0", done, plen); end
    reset_all();
  endtask

  task automatic test_single();
    reset_all();
    load(0, 3, 1, 32'hA0);
    repeat (8) step();
    total++; if (got.size() != 3) begin bad++; $display("FAIL single_count got=%0d want=3", got.size()); end
    for (int n = 0; n < got.size() && n < 3; n++) begin
      total++;
      if (got[n].data !== 32'hA0 + n || got[n].tid !== 2'd0 || got[n].last !== (n == 2) || got[n].strb !== 4'(n)) begin
        bad++;
        $display("FAIL single_beat%0d got=%h/%0d/%b/%h want=%h/0/%b/%h", n, got[n].data, got[n].tid, got[n].last, got[n].strb, 32'hA0 + n, n == 2, n);
      end
    end
    total++; if (first_v != 2) begin bad++; $display("FAIL single_latency got=%0d want=2", first_v); end
    total++; if (n_done != 1) begin bad++; $display("FAIL single_done got=%0d want=1", n_done); end
    total++; if (plen !== 16'd3) begin bad++; $display("FAIL single_len got=%0d want=3", plen); end
  endtask

  task automatic test_two_src();
    int e_tid[4] = '{0, 0, 2, 2};
    int e_dat[4] = '{'h10, 'h11, 'h30, 'h31};
    int e_stp[4] = '{2, 3, 5, 6};
    reset_all();
    load(0, 2, 1, 32'h10);
    load(2, 2, 1, 32'h30);
    repeat (10) step();
    total++; if (got.size() != 4) begin bad++; $display("FAIL two_count got=%0d want=4", got.size()); end
    for (int n = 0; n < got.size() && n < 4; n++) begin
      total++;
      if (got[n].tid !== 2'(e_tid[n]) || got[n].data !== 32'(e_dat[n]) || got[n].stp != e_stp[n]) begin
        bad++;
        $display("FAIL two_beat%0d got=%0d/%h@%0d want=%0d/%h@%0d", n, got[n].tid, got[n].data, got[n].stp, e_tid[n], e_dat[n], e_stp[n]);
      end
    end
    total++; if (n_done != 2 || plen !== 16'd2) begin bad++; $display("FAIL two_done got=%0d/%0d want=2/2", n_done, plen); end
  endtask

  task automatic test_round_robin();
    reset_all();
    for (int i = 0; i < N; i++) load(i, 1, 3, 32'(i * 16));
    repeat (30) step();
    total++; if (got.size() != 12) begin bad++; $display("FAIL rr_count got=%0d want=12", got.size()); end
    for (int n = 0; n < got.size() && n < 12; n++) begin
      total++;
      if (got[n].tid !== 2'(n % 4) || got[n].data !== 32'((n % 4) * 16 + n / 4) || got[n].last !== 1'b1) begin
        bad++;
        $display("FAIL rr_beat%0d got=%0d/%h want=%0d/%h", n, got[n].tid, got[n].data, n % 4, (n % 4) * 16 + n / 4);
      end
    end
    total++; if (n_done != 12) begin bad++; $display("FAIL rr_done got=%0d want=12", n_done); end
  endtask

  task automatic test_stall();
    logic pat[12] = '{1, 1, 0, 0, 1, 0, 1, 1, 1, 1, 1, 1};
    int e_stp[4] = '{4, 6, 7, 8};
    logic p_tv, p_tl, p_tr;
    logic [W-1:0] p_td;
    logic [1:0] p_tid;
    reset_all();
    load(0, 4, 1, 32'h50);
    p_tv = 1'b0; p_tr = 1'b1; p_tl = 1'b0; p_td = '0; p_tid = '0;
    for (int k = 0; k < 12; k++) begin
      mready = pat[k];
      step();
      if (p_tv && !p_tr) begin
        total++;
        if ({s_tv, s_td, s_tl, s_tid} !== {p_tv, p_td, p_tl, p_tid}) begin
          bad++;
          $display("FAIL stall_hold@%0d got=%b/%h/%b/%0d want=%b/%h/%b/%0d", k, s_tv, s_td, s_tl, s_tid, p_tv, p_td, p_tl, p_tid);
        end
      end
      p_tv = s_tv; p_td = s_td; p_tl = s_tl; p_tid = s_tid; p_tr = s_tr;
    end
    total++; if (got.size() != 4) begin bad++; $display("FAIL stall_count got=%0d want=4", got.size()); end
    for (int n = 0; n < got.size() && n < 4; n++) begin
      total++;
      if (got[n].data !== 32'h50 + n || got[n].last !== (n == 3) || got[n].stp != e_stp[n]) begin
        bad++;
        $display("FAIL stall_beat%0d got=%h/%b@%0d want=%h/%b@%0d", n, got[n].data, got[n].last, got[n].stp, 32'h50 + n, n == 3, e_stp[n]);
      end
    end
  endtask

  task automatic test_reset_mid();
    reset_all();
    load(0, 5, 1, 32'h60);
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    total++; if ({mv, md, ms, ml, mid} !== '0) begin bad++; $display("FAIL mid_reset_out got=%b/%h/%h/%b/%0d want=0", mv, md, ms, ml, mid); end
    total++; if (tr !== '0 || done !== 1'b0 || plen !== '0) begin bad++; $display("FAIL mid_reset_misc got=%b/%b/%h want=0", tr, done, plen); end
    clear_tb();
    load(0, 1, 1, 32'h70);
    load(3, 1, 1, 32'h73);
    drive();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) step();
    total++; if (n_beats != 2) begin bad++; $display("FAIL mid_count got=%0d want=2", n_beats); end
    total++;
    if (got.size() < 2 || got[0].tid !== 2'd0 || got[0].data !== 32'h70 || got[0].stp != 2 || got[1].tid !== 2'd3 || got[1].data !== 32'h73) begin
      bad++;
      $display("FAIL mid_order got_size=%0d want=src0:70@2 then src3:73", got.size());
    end
  endtask

  task automatic test_saturate();
    reset_all();
    load(0, 70000, 1, '0);
    repeat (70006) step();
    total++; if (n_beats != 70000) begin bad++; $display("FAIL sat_count got=%0d want=70000", n_beats); end
    total++; if (n_done != 1) begin bad++; $display("FAIL sat_done got=%0d want=1", n_done); end
    total++; if (plen !== 16'hFFFF) begin bad++; $display("FAIL sat_len got=%h want=ffff", plen); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_src();
    test_round_robin();
    test_stall();
    test_reset_mid();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axis_pkt_arbiter.md
# axis_pkt_arbiter

Packet-granular round-robin arbiter sharing one AXI4-Stream master port among NUM_SRC upstream stream sources (e.g. several stream-generator masters). A grant is held for a whole packet and released only on the accepted TLAST beat, so packets never interleave. The output is registered, making M_AXIS_TVALID, TDATA, TSTRB, TLAST and TID protocol-stable regardless of upstream timing. Sits between the stream masters and the single downstream AXIS sink.

## Interface
- NUM_SRC, 4 — number of upstream sources, 2..8
- C_M_AXIS_TDATA_WIDTH, 32 — data width, multiple of 8
- LEN_WIDTH, 16 — width of the packet-length counter
- M_AXIS_ACLK  in  1  — single clock, rising edge
- M_AXIS_ARESETN  in  1  — reset, asynchronous, active-low
- S_AXIS_TVALID  in  NUM_SRC  — per-source valid
- S_AXIS_TDATA  in  NUM_SRC*C_M_AXIS_TDATA_WIDTH  — source i occupies slice i
- S_AXIS_TSTRB  in  NUM_SRC*C_M_AXIS_TDATA_WIDTH/8  — per-source strobes
- S_AXIS_TLAST  in  NUM_SRC  — per-source last
- S_AXIS_TREADY  out  NUM_SRC  — per-source ready, one-hot or zero
- M_AXIS_TVALID  out  1  — output valid (registered)
- M_AXIS_TDATA  out  C_M_AXIS_TDATA_WIDTH  — output data (registered)
- M_AXIS_TSTRB  out  C_M_AXIS_TDATA_WIDTH/8  — output strobes (registered)
- M_AXIS_TLAST  out  1  — output last (registered)
- M_AXIS_TID  out  clog2(NUM_SRC)  — source index of the current beat (registered)
- M_AXIS_TREADY  in  1  — downstream ready
- pkt_done  out  1  — one-cycle pulse when a TLAST beat is accepted from a source
- pkt_len  out  LEN_WIDTH  — beat count of the last completed packet; saturates at all-ones

## Operation
- States: IDLE (no grant), PKT (grant held on `grant` index).
- IDLE: if any S_AXIS_TVALID is high, pick the first valid source after `last_grant`, scanning upward with wrap. Register it into `grant`, then go to PKT. No source is ready in IDLE.
- PKT: `accept = S_AXIS_TVALID[grant] && S_AXIS_TREADY[grant]`.
  - `S_AXIS_TREADY[grant] = !M_AXIS_TVALID || M_AXIS_TREADY`. All other readies are 0.
- On `accept`: the output register loads the slice for `grant`, TLAST, and TID = grant. M_AXIS_TVALID goes to 1. The beat counter increments, saturating.
- On `accept` with TLAST:
  - `last_grant <= grant`; state returns to IDLE.
  - Fire `pkt_done`; `pkt_len` gets the beat count including this beat; the beat counter clears.
- Output register:
  - Cleared (TVALID = 0) when `M_AXIS_TREADY && M_AXIS_TVALID && !accept`.
  - Otherwise held unchanged while TVALID = 1 and TREADY = 0. This is the AXIS stability rule: no change of TVALID, TDATA, TSTRB, TLAST or TID until the handshake.
- A grant is never revoked mid-packet. A granted source that deasserts TVALID stalls the arbiter in PKT indefinitely.
- Fairness: after a packet from source k, source k has lowest priority at the next arbitration.
- Simultaneous events:
  - A TLAST beat accepted while the previous beat drains downstream in the same cycle is legal.
  - The next arbitration happens in the following IDLE cycle, while the last beat may still sit in the output register.

## Timing
- Reset values (asynchronous assertion, synchronous release):
  - State IDLE; `grant` = 0; `last_grant` = NUM_SRC-1, so source 0 wins first.
  - All outputs 0: M_AXIS_TVALID/TDATA/TSTRB/TLAST/TID, S_AXIS_TREADY, pkt_done, pkt_len; beat counter 0.
- Latency:
  - S_AXIS_TVALID seen in IDLE at edge N → grant registered at N+1 → S_AXIS_TREADY high during cycle N+1 → M_AXIS_TVALID high after edge N+2.
- Throughput: 1 beat/cycle within a packet when M_AXIS_TREADY = 1. There is exactly one bubble cycle (IDLE) between packets.
- S_AXIS_TREADY depends combinationally on M_AXIS_TREADY. This is the only combinational input-to-output path.
- Reset mid-packet: the in-flight beat and the remainder of the grant are discarded. The block restarts in IDLE. Upstream sources are reset by the same M_AXIS_ARESETN.

## Structure
- Package `axis_arb_pkg`: the state enum (IDLE, PKT) and the function `idx_width(n)` (clog2 with minimum 1).
- Sub-module `axis_rr_pick`: combinational round-robin picker with inputs `req[NUM_SRC]` and `last[idx]`, and outputs `gnt_idx` and `gnt_any`. The top level holds the FSM, output register and counters.

## Test plan
- Reset, then src0 sends 3 beats (0xA0..0xA2, TLAST on the 3rd) with TREADY = 1 → TID = 0, data in order, TVALID first high 2 cycles after src0 TVALID; pkt_done pulses once; pkt_len = 3.
- src0 and src2 both valid after reset, 2-beat packets each → src0's packet first, then src2's, no interleave; exactly one IDLE bubble between them.
- All 4 sources continuously valid, 1-beat packets → TID sequence 0,1,2,3,0,1…
- Downstream stalls: TREADY toggles 0,0,1,0,1,1 during a 4-beat packet → M_AXIS_TDATA/TLAST/TID never change while TVALID = 1 and TREADY = 0; all 4 beats delivered once each.
- Reset asserted mid-packet (after beat 2 of 5) → all outputs 0 asynchronously; after release, the first grant goes to the lowest-numbered valid source.
- A 70000-beat packet with LEN_WIDTH = 16 → pkt_len = 0xFFFF (saturated).
